inst_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage directly upstream of the 64x32 instruction ROM.
- Drives the ROM word address each cycle and captures the ROM's registered instruction output one clock later.
- Presents instruction + PC to decode over a valid/ready handshake.
- Branch/jump redirect flushes all in-flight and buffered instructions.

---
 rtl/inst_fetch_unit.sv | 123 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// PC sequencing and fetch stage in front of a registered instruction ROM.
// A one-entry skid buffer absorbs the single in-flight response when decode stalls.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] Inst_addr,
    input  logic [31:0]       Inst_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc
);

    logic [31:0] pc_q, pc_d;
    logic        req_v_q, req_v_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        accept_s;
    logic        issue_s;
    logic [1:0]  unused_redirect_lsb_s;

    assign unused_redirect_lsb_s = redirect_pc[1:0];
    assign accept_s = out_valid_q && out_ready;
    // Never issue unless the response is guaranteed a slot next cycle.
    assign issue_s  = fetch_en && !skid_v_q && !(out_valid_q && !out_ready) && !redirect_valid;

    assign Inst_addr = pc_q[ADDR_W+1:2];
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;

    // Next-state: issue, response placement, drain and redirect flush.
    always_comb begin
        pc_d        = pc_q;
        req_v_d     = 1'b0;
        req_pc_d    = req_pc_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        skid_v_d    = skid_v_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if (redirect_valid) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
            skid_v_d    = 1'b0;
        end else begin
            if (issue_s) begin
                req_v_d  = 1'b1;
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end else begin
                req_v_d  = 1'b0;
            end
            if (req_v_q) begin
                if (!out_valid_q || accept_s) begin
                    if (skid_v_q) begin
                        // Skid is older than the arriving word, so it moves up first.
                        out_inst_d  = skid_inst_q;
                        out_pc_d    = skid_pc_q;
                        skid_inst_d = Inst_code;
                        skid_pc_d   = req_pc_q;
                    end else begin
                        out_inst_d  = Inst_code;
                        out_pc_d    = req_pc_q;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    skid_inst_d = Inst_code;
                    skid_pc_d   = req_pc_q;
                    skid_v_d    = 1'b1;
                end
            end else if (accept_s) begin
                if (skid_v_q) begin
                    out_inst_d = skid_inst_q;
                    out_pc_d   = skid_pc_q;
                    skid_v_d   = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= {RESET_PC[31:2], 2'b00};
            req_v_q     <= 1'b0;
            req_pc_q    <= 32'd0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_pc_q    <= 32'd0;
            skid_v_q    <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            req_v_q     <= req_v_d;
            req_pc_q    <= req_pc_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            skid_v_q    <= skid_v_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed cycle table, wrap instance,
// and a randomized run against a queue-based reference model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0]  inst_addr;
    logic [31:0] inst_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic [5:0]  w_addr;
    logic [31:0] w_code;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;

    logic [31:0] rom [64];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .Inst_addr(inst_addr), .Inst_code(inst_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    inst_fetch_unit #(.RESET_PC(32'h0000_00FC), .ADDR_W(6)) u_wrap (
        .clk(clk), .rst(rst), .fetch_en(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .Inst_addr(w_addr), .Inst_code(w_code),
        .out_valid(w_valid), .out_ready(1'b1),
        .out_inst(w_inst), .out_pc(w_pc)
    );

    // Registered ROMs: data appears the cycle after the address.
    always @(posedge clk) begin
        inst_code <= rom[inst_addr];
        w_code    <= rom[w_addr];
    end

    // Reference model: FIFO of fetched-but-undelivered PCs plus one in-flight fetch.
    logic [31:0] m_q[$];
    bit          m_inf_v = 1'b0;
    logic [31:0] m_inf_pc = 32'd0;
    logic [31:0] m_pc = 32'd0;
    always @(posedge clk) begin
        int  sz;
        bit  iss;
        sz = m_q.size();
        if (rst) begin
            m_q.delete();
            m_inf_v = 1'b0;
            m_pc    = 32'd0;
        end else begin
            iss = fetch_en && (sz < 2) && !(sz > 0 && !out_ready) && !redirect_valid;
            if (sz > 0 && out_ready) void'(m_q.pop_front());
            if (redirect_valid) begin
                m_q.delete();
                m_inf_v = 1'b0;
                m_pc    = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (m_inf_v) m_q.push_back(m_inf_pc);
                m_inf_v = iss;
                if (iss) begin
                    m_inf_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end
        end
    end

    // Log of PCs handed to decode during the directed phase.
    bit          log_en = 1'b0;
    logic [31:0] deliv[$];
    always @(posedge clk) begin
        if (log_en && !rst && out_valid && out_ready) deliv.push_back(out_pc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int count_pc(input logic [31:0] pc);
        int n = 0;
        foreach (deliv[i]) if (deliv[i] == pc) n++;
        return n;
    endfunction

    typedef struct {
        bit          rst;
        bit          fen;
        bit          rdv;
        logic [31:0] rdpc;
        bit          rdy;
        bit          ev;
        logic [31:0] epc;
        logic [5:0]  eaddr;
    } vec_t;

    function automatic vec_t row(input bit r, input bit f, input bit rv, input logic [31:0] rp,
                                 input bit rd, input bit ev, input logic [31:0] ep,
                                 input logic [5:0] ea);
        vec_t v;
        v.rst = r; v.fen = f; v.rdv = rv; v.rdpc = rp; v.rdy = rd;
        v.ev = ev; v.epc = ep; v.eaddr = ea;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        logic [31:0] exp_inst;
        // Inputs applied during cycle k; expectations observed after that cycle's edge.
        tbl[0]  = row(0,1,0,32'h0, 1, 0,32'h00, 6'd1);
        tbl[1]  = row(0,1,0,32'h0, 1, 1,32'h00, 6'd2);
        tbl[2]  = row(0,1,0,32'h0, 1, 1,32'h04, 6'd3);
        tbl[3]  = row(0,1,0,32'h0, 1, 1,32'h08, 6'd4);
        tbl[4]  = row(0,1,0,32'h0, 1, 1,32'h0C, 6'd5);
        tbl[5]  = row(0,1,0,32'h0, 1, 1,32'h10, 6'd6);
        tbl[6]  = row(0,1,0,32'h0, 0, 1,32'h10, 6'd6);
        tbl[7]  = row(0,1,0,32'h0, 0, 1,32'h10, 6'd6);
        tbl[8]  = row(0,1,0,32'h0, 0, 1,32'h10, 6'd6);
        tbl[9]  = row(0,1,0,32'h0, 1, 1,32'h14, 6'd6);
        tbl[10] = row(0,1,0,32'h0, 1, 0,32'h00, 6'd7);
        tbl[11] = row(0,1,0,32'h0, 1, 1,32'h18, 6'd8);
        tbl[12] = row(0,1,0,32'h0, 1, 1,32'h1C, 6'd9);
        tbl[13] = row(0,1,0,32'h0, 0, 1,32'h1C, 6'd9);
        tbl[14] = row(0,1,1,32'h23,0, 0,32'h00, 6'd8);
        tbl[15] = row(0,1,0,32'h0, 1, 0,32'h00, 6'd9);
        tbl[16] = row(0,1,0,32'h0, 1, 1,32'h20, 6'd10);
        tbl[17] = row(0,1,0,32'h0, 1, 1,32'h24, 6'd11);
        tbl[18] = row(0,1,1,32'h40,1, 0,32'h00, 6'd16);
        tbl[19] = row(0,1,0,32'h0, 1, 0,32'h00, 6'd17);
        tbl[20] = row(0,1,0,32'h0, 1, 1,32'h40, 6'd18);
        tbl[21] = row(0,1,0,32'h0, 0, 1,32'h40, 6'd18);
        tbl[22] = row(1,1,0,32'h0, 0, 0,32'h00, 6'd0);
        tbl[23] = row(0,1,0,32'h0, 1, 0,32'h00, 6'd1);
        tbl[24] = row(0,1,0,32'h0, 1, 1,32'h00, 6'd2);
        tbl[25] = row(0,0,0,32'h0, 1, 1,32'h04, 6'd2);
        tbl[26] = row(0,0,0,32'h0, 1, 0,32'h00, 6'd2);
        tbl[27] = row(0,1,0,32'h0, 1, 0,32'h00, 6'd3);
        tbl[28] = row(0,1,0,32'h0, 1, 1,32'h08, 6'd4);

        foreach (rom[i]) rom[i] = i;
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_addr", {26'd0, inst_addr}, 32'd0);
        chk("reset_wrap_addr", {26'd0, w_addr}, 32'd63);

        log_en = 1'b1;
        for (int k = 0; k < 29; k++) begin
            rst = tbl[k].rst; fetch_en = tbl[k].fen; redirect_valid = tbl[k].rdv;
            redirect_pc = tbl[k].rdpc; out_ready = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), {31'd0, out_valid}, {31'd0, tbl[k].ev});
            chk($sformatf("tbl%0d_addr", k), {26'd0, inst_addr}, {26'd0, tbl[k].eaddr});
            if (tbl[k].ev) begin
                exp_inst = {26'd0, tbl[k].epc[7:2]};
                chk($sformatf("tbl%0d_pc", k), out_pc, tbl[k].epc);
                chk($sformatf("tbl%0d_inst", k), out_inst, exp_inst);
            end
            if (k == 0) chk("wrap_addr0", {26'd0, w_addr}, 32'd0);
            if (k == 1) begin
                chk("wrap_valid1", {31'd0, w_valid}, 32'd1);
                chk("wrap_pc1", w_pc, 32'h0000_00FC);
                chk("wrap_inst1", w_inst, 32'd63);
            end
            if (k == 2) begin
                chk("wrap_pc2", w_pc, 32'h0000_0100);
                chk("wrap_inst2", w_inst, 32'd0);
            end
        end
        log_en = 1'b0;
        chk("stall_no_dup_0x14", count_pc(32'h14), 32'd1);
        chk("redir_same_cycle_once_0x24", count_pc(32'h24), 32'd1);
        chk("redir_flushed_0x28", count_pc(32'h28), 32'd0);
        chk("redir_flushed_0x1c", count_pc(32'h1C), 32'd0);
        chk("reset_flushed_0x44", count_pc(32'h44), 32'd0);

        // Randomized phase with random ROM contents.
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        foreach (rom[i]) rom[i] = $urandom();
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom();
            @(negedge clk);
            chk("rnd_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
            chk("rnd_addr", {26'd0, inst_addr}, {26'd0, m_pc[7:2]});
            if (m_q.size() > 0) begin
                chk("rnd_pc", out_pc, m_q[0]);
                chk("rnd_inst", out_inst, rom[m_q[0][7:2]]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
